// File: rtl/md_unit_if.sv
// Interface bundle for the multiply/divide unit: E-stage request plus HI/LO read-back.
interface md_unit_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    // Pipeline side drives the request and observes status and HI/LO.
    modport master (
        output start, md_op, a, b,
        input  busy, hi, lo, md_out
    );

    // Unit side consumes the request and presents status and HI/LO.
    modport slave (
        input  start, md_op, a, b,
        output busy, hi, lo, md_out
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// The result is computed at launch into staging registers and committed to
// HI/LO after a fixed busy period, so HI/LO only ever show committed values.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic      clk_i,
    input logic      rst_ni,
    md_unit_if.slave md_if
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [31:0]       hi_n_q, hi_n_d, lo_n_q, lo_n_d;

    logic [63:0]       prod_s, prod_u;
    logic [31:0]       a_mag, b_mag, b_safe, q_mag, r_mag;
    logic [31:0]       q_s, r_s, q_u, r_u;
    logic              b_zero;

    // Datapath: both products and both divisions from the current operands.
    always_comb begin
        prod_s = {{32{md_if.a[31]}}, md_if.a} * {{32{md_if.b[31]}}, md_if.b};
        prod_u = {32'd0, md_if.a} * {32'd0, md_if.b};
        b_zero = (md_if.b == 32'd0);
        b_safe = b_zero ? 32'd1 : md_if.b;
        // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        a_mag  = md_if.a[31] ? (~md_if.a + 32'd1) : md_if.a;
        b_mag  = md_if.b[31] ? (~b_safe + 32'd1) : b_safe;
        q_mag  = a_mag / b_mag;
        r_mag  = a_mag % b_mag;
        q_s    = (md_if.a[31] ^ md_if.b[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s    = md_if.a[31] ? (~r_mag + 32'd1) : r_mag;
        q_u    = md_if.a / b_safe;
        r_u    = md_if.a % b_safe;
    end

    // Next-state: launch, countdown/commit, and mthi/mtlo writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        unique case (state_q)
            StIdle: begin
                if (md_if.start) begin
                    state_d = StRun;
                    case (md_op_i_sel(md_if.md_op))
                        OpMult: begin
                            hi_n_d = prod_s[63:32];
                            lo_n_d = prod_s[31:0];
                            cnt_d  = CntW'(MULT_CYCLES);
                        end
                        OpMultu: begin
                            hi_n_d = prod_u[63:32];
                            lo_n_d = prod_u[31:0];
                            cnt_d  = CntW'(MULT_CYCLES);
                        end
                        OpDiv, OpDivu: begin
                            // Divide by zero commits the current HI/LO back unchanged.
                            hi_n_d = b_zero ? hi_q : ((md_if.md_op == OpDiv) ? r_s : r_u);
                            lo_n_d = b_zero ? lo_q : ((md_if.md_op == OpDiv) ? q_s : q_u);
                            cnt_d  = CntW'(DIV_CYCLES);
                        end
                        default: state_d = StIdle;
                    endcase
                end else if (md_if.md_op == OpMthi) begin
                    hi_d = md_if.a;
                end else if (md_if.md_op == OpMtlo) begin
                    lo_d = md_if.a;
                end
            end
            StRun: begin
                if (cnt_q <= CntW'(1)) begin
                    hi_d    = hi_n_q;
                    lo_d    = lo_n_q;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Only start-type ops select a launch; anything else maps to "none".
    function automatic logic [3:0] md_op_i_sel(input logic [3:0] op);
        return (op >= OpMult && op <= OpDivu) ? op : 4'd0;
    endfunction

    // State, counter, architectural and staging registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_n_q  <= '0;
            lo_n_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
        end
    end

    // Outputs: busy tracks RUN, md_out reads committed HI/LO only.
    always_comb begin
        md_if.busy = (state_q == StRun);
        md_if.hi   = hi_q;
        md_if.lo   = lo_q;
        unique case (md_if.md_op)
            OpMfhi:  md_if.md_out = hi_q;
            OpMflo:  md_if.md_out = lo_q;
            default: md_if.md_out = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with a queue of expected HI/LO results.
module tb_md_unit;
    logic clk;
    logic rst_n;

    md_unit_if bus ();

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .md_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result, independent of the RTL datapath structure.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint          sp;
        longint unsigned up;
        longint          sq, sr;
        int              sa, sb;
        sa = a;
        sb = b;
        eh = m_hi;
        el = m_lo;
        case (op)
            4'd1: begin
                sp = longint'(sa) * longint'(sb);
                eh = sp[63:32];
                el = sp[31:0];
            end
            4'd2: begin
                up = {32'd0, a} * {32'd0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            4'd3: if (b != 0) begin
                sq = longint'(sa) / longint'(sb);
                sr = longint'(sa) % longint'(sb);
                eh = sr[31:0];
                el = sq[31:0];
            end
            4'd4: if (b != 0) begin
                eh = a % b;
                el = a / b;
            end
            default: ;
        endcase
    endtask

    // Launch an op, count busy cycles, then compare the committed result.
    // With peek set, md_out is probed mid-run and a stray start is injected.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit peek);
        exp_t e;
        int   cyc;
        int   want;
        model(op, a, b, e.hi, e.lo);
        exp_q.push_back(e);
        want = (op <= 4'd2) ? 5 : 10;
        bus.start = 1'b1;
        bus.md_op = op;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (peek && cyc == 2) begin
                bus.md_op = 4'd5;
                #1 check({tag, "_mdout_hi_run"}, bus.md_out, m_hi);
                bus.md_op = 4'd6;
                #1 check({tag, "_mdout_lo_run"}, bus.md_out, m_lo);
                bus.md_op = 4'd0;
            end
            if (peek && cyc == 4) begin
                bus.start = 1'b1;
                bus.md_op = 4'd1;
            end
            step();
            bus.start = 1'b0;
            bus.md_op = 4'd0;
        end
        check({tag, "_busy_cycles"}, 32'(cyc), 32'(want));
        e = exp_q.pop_front();
        check({tag, "_hi"}, bus.hi, e.hi);
        check({tag, "_lo"}, bus.lo, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        bus.md_op = 4'd5;
        #1 check("rst_mdout", bus.md_out, 32'd0);
        bus.md_op = 4'd0;
        step();
        step();
        rst_n = 1'b1;

        // Signed and unsigned multiply.
        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo_const", bus.lo, 32'hFFFF_FFFA);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_hi_const", bus.hi, 32'hFFFF_FFFE);

        // Signed divide, divide by zero, overflow corner.
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo_const", bus.lo, 32'hFFFF_FFFD);
        check("div_hi_const", bus.hi, 32'hFFFF_FFFF);
        run_op("divu_by0", 4'd4, 32'd7, 32'd0, 1'b0);
        check("divu_by0_hi_kept", bus.hi, 32'hFFFF_FFFF);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lo_const", bus.lo, 32'h8000_0000);
        run_op("divu", 4'd4, 32'd100, 32'd7, 1'b0);

        // mthi / mtlo and md_out reads.
        bus.md_op = 4'd7;
        bus.a     = 32'h1234_5678;
        step();
        m_hi = 32'h1234_5678;
        check("mthi_hi", bus.hi, m_hi);
        bus.md_op = 4'd5;
        #1 check("mfhi_mdout", bus.md_out, m_hi);
        bus.md_op = 4'd6;
        #1 check("mflo_mdout", bus.md_out, m_lo);
        bus.md_op = 4'd8;
        bus.a     = 32'hCAFE_F00D;
        step();
        m_lo = 32'hCAFE_F00D;
        check("mtlo_lo", bus.lo, m_lo);
        bus.md_op = 4'd0;
        #1 check("none_mdout", bus.md_out, 32'd0);

        // mthi with start high is not a write; illegal op with start is ignored.
        bus.start = 1'b1;
        bus.md_op = 4'd7;
        bus.a     = 32'hDEAD_BEEF;
        step();
        check("mthi_start_ignored", bus.hi, m_hi);
        check("mthi_start_nobusy", {31'd0, bus.busy}, 32'd0);
        bus.md_op = 4'd9;
        step();
        check("op9_nobusy", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        check("op9_hi", bus.hi, m_hi);

        // Asynchronous reset at busy cycle 3 aborts the mult.
        bus.start = 1'b1;
        bus.md_op = 4'd1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        step();
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        rst_n = 1'b1;
        step();
        run_op("post_rst_mult", 4'd1, 32'd6, 32'hFFFF_FFF9, 1'b0);

        // Back-to-back: the div starts in the first IDLE cycle, using the fresh LO.
        run_op("b2b_mult", 4'd1, 32'd3, 32'd5, 1'b0);
        run_op("b2b_div", 4'd3, m_lo, 32'd4, 1'b1);
        check("b2b_div_lo_const", bus.lo, 32'd3);
        check("b2b_div_hi_const", bus.hi, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration in cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration in cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage pulse that launches the mult/multu/div/divu operation given by md_op.
REQ-006 md_op  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 are treated as none.
REQ-007 a  input  32  rs operand, already forwarded.
REQ-008 b  input  32  rt operand, already forwarded.
REQ-009 busy  output  1  high while an operation is in flight; the hazard unit consumes start OR busy.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.
REQ-012 md_out  output  32  combinational read value: hi when md_op=5, lo when md_op=6, otherwise 0.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-014 In IDLE with start=1 and md_op in 1..4, the block SHALL capture the op, compute the result into internal staging registers hi_n/lo_n, load the counter with the cycle count, and enter RUN.
- Cycle count: MULT_CYCLES for ops 1-2; DIV_CYCLES for ops 3-4.
REQ-015 mult SHALL produce signed a*b as a 64-bit product, multu SHALL produce unsigned a*b; hi_n = product[63:32], lo_n = product[31:0].
REQ-016 div SHALL produce signed quotient to lo_n and signed remainder to hi_n, with the remainder taking the sign of the dividend; divu SHALL produce the unsigned quotient and remainder.
REQ-017 If b=0 on div/divu, the block SHALL still run DIV_CYCLES, then leave hi and lo unchanged.
REQ-018 For signed div of 0x80000000 by 0xFFFFFFFF, the block SHALL produce lo=0x80000000 and hi=0.
REQ-019 busy SHALL equal 1 exactly while in RUN: it rises the cycle after start and stays high for exactly N cycles, where N is the loaded cycle count.
REQ-020 In RUN the counter SHALL decrement by 1 each cycle; on the edge where the counter equals 1, the block SHALL write hi<=hi_n and lo<=lo_n, return to IDLE, and drop busy.
REQ-021 start while in RUN SHALL be ignored; the hazard unit guarantees this case does not occur, and the block stays robust to it.
REQ-022 start with md_op outside 1..4 SHALL be ignored.
REQ-023 md_op=7 (mthi) SHALL write hi<=a on the next edge, and md_op=8 (mtlo) SHALL write lo<=a on the next edge, with two conditions:
- state is IDLE;
- start=0 (mthi/mtlo are not start-type ops).
REQ-024 mthi and mtlo in RUN SHALL be ignored; the hazard unit stalls them in D, so this case does not occur.
REQ-025 md_out SHALL reflect committed hi/lo only and SHALL NOT expose staging values.
REQ-026 Back-to-back operation: start may be accepted in the first IDLE cycle after commit, and the new operation reads the freshly committed hi/lo values.

Reset
REQ-027 reset=0 SHALL immediately force the following, independent of clk:
- state=IDLE;
- busy=0, counter=0, hi=0, lo=0;
- staging registers hi_n/lo_n=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no commit to hi or lo.
REQ-029 After reset deasserts, the first rising edge SHALL accept start normally.

Verification
REQ-030 mult, a=0xFFFFFFFE (-2), b=3 -> busy high for cycles 1-5 after start, then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-031 multu, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles, hi=0xFFFFFFFE and lo=0x00000001.
REQ-032 div, a=-7 (0xFFFFFFF9), b=2 -> busy high 10 cycles, then lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1); divu, a=7, b=0 -> after 10 busy cycles, hi and lo keep their prior values.
REQ-033 mthi a=0x12345678, then mflo/mfhi -> hi=0x12345678, md_out=0x12345678 with md_op=5, and md_out=lo with md_op=6.
REQ-034 reset=0 at busy cycle 3 of a mult -> busy=0, hi=lo=0 immediately; a subsequent start completes correctly after 5 cycles.
REQ-035 start in the same cycle busy falls, with commit of a previous mult -> the new div reads the updated hi/lo; md_out during RUN shows the old committed values.
